rf_wr_arbiter: RTL and testbench
================================

Name: rf_wr_arbiter

Overview:
- Shares the single register-file write port (wEna/wAddr/wDin) between two writeback requesters, using round-robin arbitration and a valid/ready handshake.
- Contains a clear sequencer that walks every register and writes zero, on command.
- Sits between the writeback sources (e.g. ALU result, memory load) and the register file.
- All write-port outputs are registered.

Parameters:
- AW, 6, register address width.
- DW, 32, register data width.
- DEPTH, 64, number of registers swept by a clear; must equal 2**AW.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- req0_valid  in  1  requester 0 has a write pending.
- req0_ready  out  1  requester 0 write accepted this cycle.
- req0_addr  in  AW  requester 0 destination register.
- req0_data  in  DW  requester 0 write data.
- req1_valid  in  1  requester 1 has a write pending.
- req1_ready  out  1  requester 1 write accepted this cycle.
- req1_addr  in  AW  requester 1 destination register.
- req1_data  in  DW  requester 1 write data.
- clr_start  in  1  single-cycle pulse; requests a full clear.
- clr_busy  out  1  clear sweep in progress.
- clr_done  out  1  one-cycle pulse on the last clear write.
- wEna  out  1  register-file write enable (registered).
- wAddr  out  AW  register-file write address (registered).
- wDin  out  DW  register-file write data (registered).

Behaviour:
- Clock and reset: one clock domain; reset is synchronous and active-high.
- Reset values:
  - state=IDLE, rr_pref=0 (requester 0 preferred), clear counter=0.
  - wEna=0, wAddr=0, wDin=0.
  - clr_busy=0, clr_done=0.
  - req0_ready=0 and req1_ready=0 while rst=1.
- States:
  - IDLE: arbitrate requesters.
  - CLEAR: sweep addresses.
- IDLE, clear request:
  - If clr_start=1, go to CLEAR with counter=0.
  - No grant that cycle: both readies 0, wEna<=0.
  - clr_start wins over simultaneous requests.
- IDLE, arbitration (clr_start=0); readies are combinational from the valids, state, rst and clr_start:
  - Only req0_valid: req0_ready=1.
  - Only req1_valid: req1_ready=1.
  - Both valid: grant the requester indicated by rr_pref.
  - Neither valid: no grant; wEna<=0.
  - At most one ready is high in any cycle.
  - A ready is never high without its matching valid.
- Transfer:
  - A write transfers on a clock edge where reqN_valid&reqN_ready.
  - On that edge: wEna<=1, wAddr<=reqN_addr, wDin<=reqN_data, rr_pref<=other requester.
  - Latency: the write appears on the port exactly 1 cycle after acceptance.
  - Throughput: 1 write per cycle.
- Stalls: a requester not granted holds valid/addr/data stable until ready; the bench checks this, the block does not.
- CLEAR:
  - Both readies forced to 0.
  - clr_busy=1 combinationally while in CLEAR.
  - Each cycle: wEna<=1, wAddr<=counter, wDin<=0, counter<=counter+1.
  - On the edge issuing address DEPTH-1: clr_done<=1 and state<=IDLE.
  - wEna/wAddr/wDin and clr_done change on the same edge, so clr_done is high in the same cycle the address-DEPTH-1 write is presented.
  - clr_done<=0 on all other edges.
  - clr_start received during CLEAR is ignored; the sweep is not restarted.
  - rr_pref is unchanged by a clear.
  - A clear sweep takes exactly DEPTH cycles of write-port occupancy.
- Counter wrap: the counter is AW bits; after DEPTH-1 it wraps to 0 and is unused until the next clear.
- Reset mid-clear: the next edge returns all state and outputs to reset values; the sweep is abandoned and no clr_done is issued.
- Reset mid-handshake: a transfer whose valid&ready edge coincides with rst=1 is dropped (readies are 0 during reset).
- Address/data are passed through unmodified. No write is suppressed by address; address 0 is an ordinary register.
- Same-address writes on consecutive cycles from different requesters: both are issued in grant order; the later write wins in the register file.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> wEna=0, wAddr=0, wDin=0, clr_busy=0, clr_done=0; both readies 0.
- Single requester: req0_valid=1, addr=5, data=0xDEADBEEF for 1 cycle -> req0_ready=1 same cycle; next cycle wEna=1, wAddr=5, wDin=0xDEADBEEF; following cycle wEna=0.
- Contention round-robin: both valid continuously, req0 (addr 1, 0x11) and req1 (addr 2, 0x22), from reset -> grants alternate 0,1,0,1; write port shows addr 1,2,1,2 on consecutive cycles; never two readies at once.
- Clear sweep: clr_start pulse in IDLE with req1_valid=1 -> req1_ready=0; clr_busy high for 64 cycles; wAddr walks 0..63 with wDin=0 and wEna=1; clr_done=1 only with wAddr=63; req1 granted on the first IDLE cycle after the sweep.
- Clear interference: second clr_start at sweep address 20 -> ignored; sweep still ends at 63 with exactly one clr_done pulse.
- Reset mid-clear: assert rst at sweep address 30 -> next cycle wEna=0 and clr_busy=0, no clr_done; after release, req0 write to addr 7 goes through with 1-cycle latency.

Source files
------------

// File: rtl/rf_wr_arbiter.sv
// Round-robin arbiter sharing one register-file write port between two
// writeback requesters, plus a sequencer that zeroes every register on command.
module rf_wr_arbiter #(
  parameter int AW    = 6,
  parameter int DW    = 32,
  parameter int DEPTH = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_data,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_data,
  input  logic          clr_start,
  output logic          clr_busy,
  output logic          clr_done,
  output logic          wEna,
  output logic [AW-1:0] wAddr,
  output logic [DW-1:0] wDin
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  if (DEPTH != (1 << AW)) begin : g_depth_check
    $error("rf_wr_arbiter: DEPTH must equal 2**AW");
  end

  state_t        r_state;
  logic          r_rr_pref;  // 0: requester 0 wins a tie, 1: requester 1 wins
  logic [AW-1:0] r_cnt;

  logic w_arb_ok;
  logic w_gnt0;
  logic w_gnt1;

  // A grant is only possible in IDLE outside reset, and a clear request
  // pre-empts any pending writes in the same cycle.
  assign w_arb_ok = !rst && (r_state == IDLE) && !clr_start;
  assign w_gnt0   = w_arb_ok && req0_valid && (!req1_valid || !r_rr_pref);
  assign w_gnt1   = w_arb_ok && req1_valid && (!req0_valid ||  r_rr_pref);

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;
  assign clr_busy   = (r_state == CLEAR);

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_rr_pref <= 1'b0;
      r_cnt     <= '0;
      wEna      <= 1'b0;
      wAddr     <= '0;
      wDin      <= '0;
      clr_done  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          clr_done <= 1'b0;
          if (clr_start) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
            wEna    <= 1'b0;
          end else if (w_gnt0) begin
            wEna      <= 1'b1;
            wAddr     <= req0_addr;
            wDin      <= req0_data;
            r_rr_pref <= 1'b1;
          end else if (w_gnt1) begin
            wEna      <= 1'b1;
            wAddr     <= req1_addr;
            wDin      <= req1_data;
            r_rr_pref <= 1'b0;
          end else begin
            wEna <= 1'b0;
          end
        end

        CLEAR: begin
          wEna  <= 1'b1;
          wAddr <= r_cnt;
          wDin  <= '0;
          r_cnt <= r_cnt + 1'b1;
          // The done pulse lands together with the final zero write.
          if (r_cnt == LAST_ADDR) begin
            clr_done <= 1'b1;
            r_state  <= IDLE;
          end else begin
            clr_done <= 1'b0;
          end
        end

        default: begin
          r_state  <= IDLE;
          wEna     <= 1'b0;
          clr_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Directed self-checking bench for rf_wr_arbiter: reset, single writes,
// round-robin contention, clear sweeps with interference and reset mid-clear.
module tb_rf_wr_arbiter;

  localparam int AW    = 6;
  localparam int DW    = 32;
  localparam int DEPTH = 64;

  logic          clk;
  logic          rst;
  logic          req0_valid;
  logic          req0_ready;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_data;
  logic          req1_valid;
  logic          req1_ready;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_data;
  logic          clr_start;
  logic          clr_busy;
  logic          clr_done;
  logic          wEna;
  logic [AW-1:0] wAddr;
  logic [DW-1:0] wDin;

  int n_tests = 0;
  int n_fail  = 0;

  rf_wr_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .clr_start  (clr_start),
    .clr_busy   (clr_busy),
    .clr_done   (clr_done),
    .wEna       (wEna),
    .wAddr      (wAddr),
    .wDin       (wDin)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Land 1 time unit after the rising edge: registered outputs are settled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_port(input string tag, input logic ena, input logic [AW-1:0] addr,
                            input logic [DW-1:0] data);
    check({tag, "_wEna"}, 64'(wEna), 64'(ena));
    if (ena) begin
      check({tag, "_wAddr"}, 64'(wAddr), 64'(addr));
      check({tag, "_wDin"},  64'(wDin),  64'(data));
    end
  endtask

  // Pulses clr_start and follows the sweep. poke_k re-pulses clr_start while
  // the counter holds that value; rst_k asserts reset at that counter value.
  task automatic do_sweep(input int poke_k, input int rst_k);
    int done_cnt;
    done_cnt  = 0;
    clr_start = 1'b1;
    #1;
    check("clr_start_rdy0", 64'(req0_ready), 64'd0);
    check("clr_start_rdy1", 64'(req1_ready), 64'd0);
    step();
    clr_start = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (k == rst_k) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstclr_wEna", 64'(wEna),     64'd0);
        check("rstclr_busy", 64'(clr_busy), 64'd0);
        check("rstclr_done", 64'(clr_done), 64'd0);
        check("rstclr_wAddr", 64'(wAddr),   64'd0);
        for (int j = 0; j < 4; j++) begin
          step();
          if (clr_done || clr_busy) done_cnt++;
        end
        check("rstclr_no_done", 64'(done_cnt), 64'd0);
        return;
      end
      check("clr_busy", 64'(clr_busy), 64'd1);
      check("clr_rdy",  64'({req0_ready, req1_ready}), 64'd0);
      if (k == 0) check("clr_first_idle", 64'(wEna), 64'd0);
      else        check_port("clr", 1'b1, AW'(k - 1), '0);
      if (clr_done) done_cnt++;
      if (k == poke_k) clr_start = 1'b1;
      step();
      clr_start = 1'b0;
    end
    check("clr_end_busy", 64'(clr_busy), 64'd0);
    check_port("clr_end", 1'b1, AW'(DEPTH - 1), '0);
    check("clr_end_done", 64'(clr_done), 64'd1);
    check("clr_prior_done", 64'(done_cnt), 64'd0);
  endtask

  initial begin
    rst        = 1'b1;
    req0_valid = 1'b0;
    req0_addr  = '0;
    req0_data  = '0;
    req1_valid = 1'b0;
    req1_addr  = '0;
    req1_data  = '0;
    clr_start  = 1'b0;

    // Reset then idle; a valid during reset is never accepted.
    step();
    req0_valid = 1'b1;
    req0_addr  = 6'd3;
    req0_data  = 32'h3333_3333;
    #1;
    check("rst_rdy0", 64'(req0_ready), 64'd0);
    check("rst_rdy1", 64'(req1_ready), 64'd0);
    step();
    check("rst_wEna",  64'(wEna),     64'd0);
    check("rst_wAddr", 64'(wAddr),    64'd0);
    check("rst_wDin",  64'(wDin),     64'd0);
    check("rst_busy",  64'(clr_busy), 64'd0);
    check("rst_done",  64'(clr_done), 64'd0);
    rst        = 1'b0;
    req0_valid = 1'b0;

    // Single requester, 1-cycle latency.
    req0_valid = 1'b1;
    req0_addr  = 6'd5;
    req0_data  = 32'hDEAD_BEEF;
    #1;
    check("single_rdy0", 64'(req0_ready), 64'd1);
    check("single_rdy1", 64'(req1_ready), 64'd0);
    step();
    req0_valid = 1'b0;
    check_port("single", 1'b1, 6'd5, 32'hDEAD_BEEF);
    step();
    check("single_after", 64'(wEna), 64'd0);

    // Contention from reset: grants alternate 0,1,0,1.
    rst = 1'b1;
    step();
    rst        = 1'b0;
    req0_valid = 1'b1;
    req0_addr  = 6'd1;
    req0_data  = 32'h11;
    req1_valid = 1'b1;
    req1_addr  = 6'd2;
    req1_data  = 32'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_rdy0", 64'(req0_ready), 64'((i % 2) == 0));
      check("rr_rdy1", 64'(req1_ready), 64'((i % 2) == 1));
      step();
      if ((i % 2) == 0) check_port("rr", 1'b1, 6'd1, 32'h11);
      else              check_port("rr", 1'b1, 6'd2, 32'h22);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    check("rr_idle", 64'(wEna), 64'd0);

    // Clear sweep with requester 1 waiting; granted right after.
    req1_valid = 1'b1;
    req1_addr  = 6'd9;
    req1_data  = 32'h99;
    do_sweep(-1, -1);
    #1;
    check("post_clr_rdy1", 64'(req1_ready), 64'd1);
    step();
    req1_valid = 1'b0;
    check_port("post_clr", 1'b1, 6'd9, 32'h99);
    check("post_clr_done", 64'(clr_done), 64'd0);

    // Second clr_start mid-sweep is ignored.
    do_sweep(20, -1);
    step();
    check("intf_done_low", 64'(clr_done), 64'd0);
    check("intf_busy_low", 64'(clr_busy), 64'd0);

    // Reset mid-clear, then an ordinary write.
    do_sweep(-1, 30);
    req0_valid = 1'b1;
    req0_addr  = 6'd7;
    req0_data  = 32'h0000_7777;
    #1;
    check("after_rst_rdy0", 64'(req0_ready), 64'd1);
    step();
    req0_valid = 1'b0;
    check_port("after_rst", 1'b1, 6'd7, 32'h0000_7777);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
